// File: rtl/lif_layer_scheduler.sv
// Shared leaky-integrate-and-fire datapath, time-multiplexed over N_NEURON
// membrane potentials and sequenced for T_STEPS timesteps per start pulse.
module lif_layer_scheduler #(
  parameter int              N_NEURON = 16,
  parameter int              IDX_W    = 4,
  parameter int              T_STEPS  = 8,
  parameter int              STEP_W   = 3,
  parameter int              TAU      = 2,
  parameter logic signed [7:0] VTH    = 8'sd0,
  parameter logic signed [7:0] VRES   = 8'sd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clr_mem,
  input  logic                abort,
  input  logic                ir_valid,
  input  logic [7:0]          ir_data,
  output logic                ir_ready,
  output logic                busy,
  output logic [IDX_W-1:0]    cur_idx,
  output logic [STEP_W-1:0]   cur_step,
  output logic [N_NEURON-1:0] spike_vec,
  output logic                step_done,
  output logic                all_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURON - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

  state_t              state;
  logic signed [7:0]   mem [N_NEURON];
  logic [N_NEURON-1:0] shadow;

  logic signed [7:0] v;
  logic signed [8:0] d9;
  logic signed [8:0] delta;
  logic signed [8:0] nv9;
  logic signed [7:0] nv;
  logic              spike;
  logic              xfer;

  assign ir_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign xfer     = ir_ready && ir_valid;

  // Leak toward the input current by 1/2**TAU of the gap, floor rounding.
  always_comb begin
    v     = mem[cur_idx];
    d9    = $signed({ir_data[7], ir_data}) - $signed({v[7], v});
    delta = d9 >>> TAU;
    nv9   = $signed({v[7], v}) + delta;
    if (nv9 > 9'sd127)
      nv = 8'sd127;
    else if (nv9 < -9'sd128)
      nv = -8'sd128;
    else
      nv = nv9[7:0];
    spike = (nv > VTH);
  end

  // NOTE: potentials are flops rather than RAM because every entry must be
  // writable in a single cycle (reset and clr_mem), so a loop reset is legal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      cur_step  <= '0;
      spike_vec <= '0;
      step_done <= 1'b0;
      all_done  <= 1'b0;
      shadow    <= '0;
      for (int i = 0; i < N_NEURON; i++) mem[i] <= VRES;
    end else begin
      step_done <= 1'b0;
      all_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cur_idx  <= '0;
            cur_step <= '0;
            if (clr_mem)
              for (int i = 0; i < N_NEURON; i++) mem[i] <= VRES;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            cur_idx  <= '0;
            cur_step <= '0;
            shadow   <= '0;
          end else if (xfer) begin
            mem[cur_idx]    <= spike ? VRES : nv;
            shadow[cur_idx] <= spike;
            if (cur_idx == LAST_IDX) begin
              spike_vec <= {spike, shadow[N_NEURON-2:0]};
              shadow    <= '0;
              step_done <= 1'b1;
              cur_idx   <= '0;
              if (cur_step < LAST_STEP) begin
                cur_step <= cur_step + 1'b1;
              end else begin
                state    <= DONE;
                all_done <= 1'b1;
              end
            end else begin
              cur_idx <= cur_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          cur_step <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed self-checking bench for lif_layer_scheduler (16 neurons, 2 steps per run).
module tb_lif_layer_scheduler;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, clr_mem, abort, ir_valid;
  logic [7:0]  ir_data;
  logic        ir_ready, busy, step_done, all_done;
  logic [3:0]  cur_idx;
  logic [0:0]  cur_step;
  logic [15:0] spike_vec;

  int tests  = 0;
  int failed = 0;
  logic [7:0] ir_tab [N];
  logic signed [7:0] exp3 [8];

  lif_layer_scheduler #(
    .N_NEURON(16), .IDX_W(4), .T_STEPS(2), .STEP_W(1), .TAU(2),
    .VTH(8'sd0), .VRES(8'sd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_mem(clr_mem), .abort(abort),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_ready(ir_ready), .busy(busy),
    .cur_idx(cur_idx), .cur_step(cur_step), .spike_vec(spike_vec),
    .step_done(step_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic clr);
    start   = 1'b1;
    clr_mem = clr;
    tick();
    start   = 1'b0;
    clr_mem = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d);
    ir_valid = 1'b1;
    ir_data  = d;
    tick();
    ir_valid = 1'b0;
  endtask

  // Back-to-back transfers of one full timestep from ir_tab.
  task automatic run_step();
    for (int i = 0; i < N; i++) begin
      ir_valid = 1'b1;
      ir_data  = ir_tab[i];
      tick();
    end
    ir_valid = 1'b0;
  endtask

  // Same timestep with random idle gaps before each transfer.
  task automatic run_step_gappy();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ir_valid = 1'b0;
        ir_data  = 8'($urandom);
        tick();
      end
      xfer(ir_tab[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr_mem = 1'b0; abort = 1'b0;
    ir_valid = 1'b0; ir_data = 8'h00;
    exp3 = '{-8'sd56, -8'sd88, -8'sd106, -8'sd116, -8'sd122, -8'sd125, -8'sd127, -8'sd128};

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ready", ir_ready, 0);
    check("rst_idx", cur_idx, 0);
    check("rst_step", cur_step, 0);
    check("rst_spk", spike_vec, 0);
    check("rst_sdone", step_done, 0);
    check("rst_adone", all_done, 0);
    rst_n = 1'b1;
    tick();

    // 1: all ir=40 -> every neuron spikes each step
    for (int i = 0; i < N; i++) ir_tab[i] = 8'd40;
    start_run(1'b1);
    check("t1_ready", ir_ready, 1);
    check("t1_busy", busy, 1);
    run_step();
    check("t1_sdone0", step_done, 1);
    check("t1_adone0", all_done, 0);
    check("t1_spk0", spike_vec, 16'hFFFF);
    check("t1_step1", cur_step, 1);
    check("t1_idx0", cur_idx, 0);
    run_step();
    check("t1_sdone1", step_done, 1);
    check("t1_adone1", all_done, 1);
    check("t1_spk1", spike_vec, 16'hFFFF);
    check("t1_done_ready", ir_ready, 0);
    check("t1_done_busy", busy, 1);
    tick();
    check("t1_idle_sdone", step_done, 0);
    check("t1_idle_adone", all_done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_step", cur_step, 0);
    check("t1_mem0", dut.mem[0], 0);
    check("t1_mem15", dut.mem[15], 0);

    // 2: neuron 0 ir=-40, others 0 -> -10 then -18, never spikes
    for (int i = 0; i < N; i++) ir_tab[i] = 8'd0;
    ir_tab[0] = 8'hD8;
    start_run(1'b1);
    run_step();
    check("t2_sdone0", step_done, 1);
    check("t2_spk0", spike_vec, 0);
    check("t2_v0_s0", dut.mem[0], -32'sd10);
    run_step();
    check("t2_sdone1", step_done, 1);
    check("t2_adone", all_done, 1);
    check("t2_spk1", spike_vec, 0);
    check("t2_v0_s1", dut.mem[0], -32'sd18);
    tick();

    // 3: neuron 3 ir=-128 across runs without clr_mem -> floors to -128 and holds
    for (int i = 0; i < N; i++) ir_tab[i] = 8'd0;
    ir_tab[3] = 8'h80;
    for (int r = 0; r < 9; r++) begin
      start_run(r == 0);
      run_step();
      run_step();
      tick();
      check($sformatf("t3_v3_run%0d", r), dut.mem[3], (r < 8) ? 32'(exp3[r]) : -32'sd128);
    end
    check("t3_spk", spike_vec, 0);
    check("t3_v4", dut.mem[4], 0);

    // 4: even ir=40 (spike), odd ir=3 (stays 0), with valid gaps
    for (int i = 0; i < N; i++) ir_tab[i] = (i % 2 == 0) ? 8'd40 : 8'd3;
    start_run(1'b1);
    for (int i = 0; i < 5; i++) xfer(ir_tab[i]);
    ir_valid = 1'b0;
    tick(); tick();
    check("t4_idx_hold", cur_idx, 5);
    for (int i = 5; i < N; i++) xfer(ir_tab[i]);
    check("t4_sdone0", step_done, 1);
    check("t4_spk0", spike_vec, 16'h5555);
    run_step_gappy();
    check("t4_adone", all_done, 1);
    check("t4_spk1", spike_vec, 16'h5555);
    tick();

    // 5: abort at neuron 7 of the first step
    for (int i = 0; i < N; i++) ir_tab[i] = 8'hD8;
    start_run(1'b1);
    check("t5_spk_kept_by_start", spike_vec, 16'h5555);
    for (int i = 0; i < 7; i++) xfer(ir_tab[i]);
    abort = 1'b1; ir_valid = 1'b1; ir_data = 8'hD8;
    tick();
    abort = 1'b0; ir_valid = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_ready", ir_ready, 0);
    check("t5_abort_idx", cur_idx, 0);
    check("t5_abort_sdone", step_done, 0);
    check("t5_abort_spk", spike_vec, 16'h5555);
    check("t5_v6", dut.mem[6], -32'sd10);
    check("t5_v7_untouched", dut.mem[7], 0);
    start_run(1'b0);
    xfer(8'hD8);
    check("t5_retained_v0", dut.mem[0], -32'sd18);
    check("t5_retained_idx", cur_idx, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    start_run(1'b1);
    check("t5_clr_v6", dut.mem[6], 0);
    xfer(8'hD8);
    check("t5_clr_v0", dut.mem[0], -32'sd10);

    // 6: start ignored in RUN; reset mid-step with start held
    start = 1'b1;
    xfer(8'hD8);
    check("t6_start_ignored", cur_idx, 2);
    rst_n = 1'b0; ir_valid = 1'b1; ir_data = 8'hD8;
    tick();
    ir_valid = 1'b0;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_idx", cur_idx, 0);
    check("t6_rst_step", cur_step, 0);
    check("t6_rst_spk", spike_vec, 0);
    check("t6_rst_sdone", step_done, 0);
    check("t6_rst_adone", all_done, 0);
    check("t6_rst_v0", dut.mem[0], 0);
    rst_n = 1'b1;
    tick();
    check("t6_restart_busy", busy, 1);
    tick();
    check("t6_run_hold_idx", cur_idx, 0);
    start = 1'b0;
    for (int i = 0; i < N; i++) ir_tab[i] = 8'd0;
    run_step();
    run_step();
    check("t6_adone", all_done, 1);
    start = 1'b1;
    tick();
    check("t6_done_start_ignored", busy, 0);
    start = 1'b0;
    tick();
    check("t6_idle_stays", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
